// File: rtl/gpu_pkg.sv
// Shared definitions for the gpu command scheduler: op codes, FSM encoding,
// coordinate widths and the packed command entry kept in the queue.
package gpu_pkg;

    localparam logic GPU_OP_DRAW  = 1'b0;
    localparam logic GPU_OP_CLEAR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_STROBE = 2'd2,
        ST_WAIT   = 2'd3
    } gpu_state_e;

    // Two spare bits let excerpts start off-screen or span the full extent.
    function automatic int gpu_coord_w(input int extent);
        return $clog2(extent) + 2;
    endfunction

    localparam int GPU_FB_WIDTH  = 400;
    localparam int GPU_FB_HEIGHT = 240;
    localparam int GPU_WX        = gpu_coord_w(GPU_FB_WIDTH);
    localparam int GPU_WY        = gpu_coord_w(GPU_FB_HEIGHT);

    typedef struct packed {
        logic              op;
        logic [31:0]       address;
        logic [15:0]       address_x;
        logic [15:0]       address_y;
        logic [15:0]       image_width;
        logic [GPU_WX-1:0] width;
        logic [GPU_WY-1:0] height;
        logic [GPU_WX-1:0] x;
        logic [GPU_WY-1:0] y;
        logic [15:0]       clear_color;
    } gpu_cmd_t;

endpackage

// File: rtl/gpu_cmd_fifo.sv
// Synchronous FIFO with occupancy count and a flush that empties it next cycle.
// Full/empty come from the registered count, so a pop never frees a slot for
// a push in the same cycle.
module gpu_cmd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign rdata   = mem[rptr];

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/gpu_cmd_queue.sv
// Queues draw/clear commands and issues them to gpu one at a time, holding the
// ctrl_* fields steady and producing a clean one-cycle draw/clear strobe.
module gpu_cmd_queue
    import gpu_pkg::*;
#(
    parameter int FB_WIDTH  = GPU_FB_WIDTH,
    parameter int FB_HEIGHT = GPU_FB_HEIGHT,
    parameter int DEPTH     = 8,
    localparam int WX       = gpu_coord_w(FB_WIDTH),
    localparam int WY       = gpu_coord_w(FB_HEIGHT),
    localparam int CW       = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_op,
    input  logic [31:0]   cmd_address,
    input  logic [15:0]   cmd_address_x,
    input  logic [15:0]   cmd_address_y,
    input  logic [15:0]   cmd_image_width,
    input  logic [WX-1:0] cmd_width,
    input  logic [WY-1:0] cmd_height,
    input  logic [WX-1:0] cmd_x,
    input  logic [WY-1:0] cmd_y,
    input  logic [15:0]   cmd_clear_color,
    input  logic          cmd_flush,

    input  logic          gpu_busy,
    output logic [31:0]   ctrl_address,
    output logic [15:0]   ctrl_address_x,
    output logic [15:0]   ctrl_address_y,
    output logic [15:0]   ctrl_image_width,
    output logic [WX-1:0] ctrl_width,
    output logic [WY-1:0] ctrl_height,
    output logic [WX-1:0] ctrl_x,
    output logic [WY-1:0] ctrl_y,
    output logic [15:0]   ctrl_clear_color,
    output logic          ctrl_draw,
    output logic          ctrl_clear,

    output logic [CW-1:0] queue_count,
    output logic          idle,
    output logic          cmd_done
);

    gpu_state_e state_q, state_d;
    gpu_cmd_t   wr_entry;
    gpu_cmd_t   head;
    logic       op_q;
    logic       fifo_full;
    logic       fifo_empty;
    logic       push;
    logic       pop;

    // Entry layout is sized by the package framebuffer; casts adapt other sizes.
    always_comb begin
        wr_entry             = '0;
        wr_entry.op          = cmd_op;
        wr_entry.address     = cmd_address;
        wr_entry.address_x   = cmd_address_x;
        wr_entry.address_y   = cmd_address_y;
        wr_entry.image_width = cmd_image_width;
        wr_entry.width       = GPU_WX'(cmd_width);
        wr_entry.height      = GPU_WY'(cmd_height);
        wr_entry.x           = GPU_WX'(cmd_x);
        wr_entry.y           = GPU_WY'(cmd_y);
        wr_entry.clear_color = cmd_clear_color;
    end

    assign cmd_ready = !fifo_full && !cmd_flush;
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state_q == ST_IDLE) && !fifo_empty && !gpu_busy && !cmd_flush;

    gpu_cmd_fifo #(
        .WIDTH ($bits(gpu_cmd_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (cmd_flush),
        .push  (push),
        .pop   (pop),
        .wdata (wr_entry),
        .rdata (head),
        .count (queue_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (pop) state_d = ST_LOAD;
            ST_LOAD:   state_d = ST_STROBE;
            ST_STROBE: state_d = ST_WAIT;
            ST_WAIT:   if (!gpu_busy) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Completion is flagged in the WAIT cycle that sees gpu idle, so the next
    // pop can follow in the very next cycle.
    assign cmd_done = (state_q == ST_WAIT) && !gpu_busy;
    assign idle     = fifo_empty && (state_q == ST_IDLE) && !gpu_busy;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= ST_IDLE;
            op_q             <= GPU_OP_DRAW;
            ctrl_address     <= '0;
            ctrl_address_x   <= '0;
            ctrl_address_y   <= '0;
            ctrl_image_width <= '0;
            ctrl_width       <= '0;
            ctrl_height      <= '0;
            ctrl_x           <= '0;
            ctrl_y           <= '0;
            ctrl_clear_color <= '0;
            ctrl_draw        <= 1'b0;
            ctrl_clear       <= 1'b0;
        end else begin
            state_q <= state_d;
            if (pop) begin
                op_q             <= head.op;
                ctrl_address     <= head.address;
                ctrl_address_x   <= head.address_x;
                ctrl_address_y   <= head.address_y;
                ctrl_image_width <= head.image_width;
                ctrl_width       <= WX'(head.width);
                ctrl_height      <= WY'(head.height);
                ctrl_x           <= WX'(head.x);
                ctrl_y           <= WY'(head.y);
                ctrl_clear_color <= head.clear_color;
            end
            // Strobe is high only during STROBE: registered on leaving LOAD.
            ctrl_draw  <= (state_q == ST_LOAD) && (op_q == GPU_OP_DRAW);
            ctrl_clear <= (state_q == ST_LOAD) && (op_q == GPU_OP_CLEAR);
        end
    end

endmodule

// File: tb/tb_gpu_cmd_queue.sv
// Randomized bench for gpu_cmd_queue against a queue-and-timeline reference
// model, with a stub gpu whose busy time is programmable per operation.
module tb_gpu_cmd_queue;

    localparam int DEPTH = 8;
    localparam int WX    = 11;
    localparam int WY    = 10;
    localparam int CW    = 4;
    localparam int FW    = 138;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid, cmd_ready, cmd_op, cmd_flush;
    logic [31:0]   cmd_address;
    logic [15:0]   cmd_address_x, cmd_address_y, cmd_image_width, cmd_clear_color;
    logic [WX-1:0] cmd_width, cmd_x;
    logic [WY-1:0] cmd_height, cmd_y;
    logic          gpu_busy;
    logic [31:0]   ctrl_address;
    logic [15:0]   ctrl_address_x, ctrl_address_y, ctrl_image_width, ctrl_clear_color;
    logic [WX-1:0] ctrl_width, ctrl_x;
    logic [WY-1:0] ctrl_height, ctrl_y;
    logic          ctrl_draw, ctrl_clear;
    logic [CW-1:0] queue_count;
    logic          idle, cmd_done;

    always #5 clk = ~clk;

    gpu_cmd_queue #(.FB_WIDTH(400), .FB_HEIGHT(240), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_address(cmd_address), .cmd_address_x(cmd_address_x),
        .cmd_address_y(cmd_address_y), .cmd_image_width(cmd_image_width),
        .cmd_width(cmd_width), .cmd_height(cmd_height), .cmd_x(cmd_x), .cmd_y(cmd_y),
        .cmd_clear_color(cmd_clear_color), .cmd_flush(cmd_flush),
        .gpu_busy(gpu_busy),
        .ctrl_address(ctrl_address), .ctrl_address_x(ctrl_address_x),
        .ctrl_address_y(ctrl_address_y), .ctrl_image_width(ctrl_image_width),
        .ctrl_width(ctrl_width), .ctrl_height(ctrl_height), .ctrl_x(ctrl_x), .ctrl_y(ctrl_y),
        .ctrl_clear_color(ctrl_clear_color), .ctrl_draw(ctrl_draw), .ctrl_clear(ctrl_clear),
        .queue_count(queue_count), .idle(idle), .cmd_done(cmd_done)
    );

    // Stub gpu: busy from the strobe cycle for op_len cycles, plus an external override.
    int op_len;
    int busy_cnt;
    bit ext_busy;
    assign gpu_busy = ext_busy | ctrl_draw | ctrl_clear | (busy_cnt != 0);
    always @(posedge clk) begin
        if (reset)                       busy_cnt <= 0;
        else if (ctrl_draw | ctrl_clear) busy_cnt <= op_len - 1;
        else if (busy_cnt != 0)          busy_cnt <= busy_cnt - 1;
    end

    typedef struct {
        bit            op;
        logic [31:0]   addr;
        logic [15:0]   ax, ay, iw;
        logic [WX-1:0] w, x;
        logic [WY-1:0] h, y;
        logic [15:0]   color;
    } cmd_s;

    cmd_s q[$];
    cmd_s cur;
    cmd_s lp;
    bit   inflight;
    int   pop_cyc;
    int   cyc;
    int   checks;
    int   failures;

    function automatic logic [FW-1:0] pack(input cmd_s c);
        return {c.addr, c.ax, c.ay, c.iw, c.w, c.h, c.x, c.y, c.color};
    endfunction

    function automatic cmd_s rand_cmd(input bit op);
        cmd_s c;
        c.op    = op;
        c.addr  = $urandom;
        c.ax    = 16'($urandom);
        c.ay    = 16'($urandom);
        c.iw    = 16'($urandom);
        c.w     = WX'($urandom);
        c.h     = WY'($urandom);
        c.x     = WX'($urandom);
        c.y     = WY'($urandom);
        c.color = 16'($urandom);
        return c;
    endfunction

    task automatic check_eq(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    task automatic drive(input bit v, input cmd_s c, input bit fl);
        cur             = c;
        cmd_valid       = v;
        cmd_flush       = fl;
        cmd_op          = c.op;
        cmd_address     = c.addr;
        cmd_address_x   = c.ax;
        cmd_address_y   = c.ay;
        cmd_image_width = c.iw;
        cmd_width       = c.w;
        cmd_height      = c.h;
        cmd_x           = c.x;
        cmd_y           = c.y;
        cmd_clear_color = c.color;
    endtask

    // One clock: compare outputs to the model, then advance the model at the edge.
    task automatic step();
        bit exp_push, exp_pop, exp_done, exp_stb;
        exp_push = 0; exp_pop = 0; exp_done = 0;
        #1;
        if (!reset) begin
            exp_stb  = inflight && (cyc == pop_cyc + 2);
            exp_done = inflight && (cyc >= pop_cyc + 3) && !gpu_busy;
            check_eq("queue_count", queue_count, q.size());
            check_eq("cmd_ready", cmd_ready, (q.size() < DEPTH) && !cmd_flush);
            check_eq("idle", idle, (q.size() == 0) && !inflight && !gpu_busy);
            check_eq("ctrl_draw", ctrl_draw, exp_stb && (lp.op == 1'b0));
            check_eq("ctrl_clear", ctrl_clear, exp_stb && (lp.op == 1'b1));
            check_eq("cmd_done", cmd_done, exp_done);
            check_eq("ctrl_fields",
                     {ctrl_address, ctrl_address_x, ctrl_address_y, ctrl_image_width,
                      ctrl_width, ctrl_height, ctrl_x, ctrl_y, ctrl_clear_color},
                     pack(lp));
            exp_push = cmd_valid && (q.size() < DEPTH) && !cmd_flush;
            exp_pop  = !inflight && (q.size() != 0) && !gpu_busy && !cmd_flush;
        end
        @(posedge clk);
        if (reset) begin
            q.delete();
            inflight = 0;
            lp = '{default: 0};
        end else begin
            if (exp_done) inflight = 0;
            if (cmd_flush) q.delete();
            else begin
                if (exp_pop) begin
                    lp = q.pop_front();
                    inflight = 1;
                    pop_cyc = cyc;
                end
                if (exp_push) q.push_back(cur);
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle_cycles(input int n);
        cmd_s z;
        z = '{default: 0};
        drive(0, z, 0);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic push_one(input cmd_s c);
        drive(1, c, 0);
        step();
        cmd_valid = 0;
    endtask

    initial begin
        cmd_s c;
        checks = 0; failures = 0; cyc = 0; inflight = 0; pop_cyc = 0;
        lp = '{default: 0};
        op_len = 4; ext_busy = 0; reset = 1;
        c = '{default: 0};
        drive(0, c, 0);
        @(negedge clk);
        step(); step();
        reset = 0;
        idle_cycles(3);

        // Single DRAW with a long gpu operation
        op_len = 128;
        c = '{op: 0, addr: 32'h1000, ax: 0, ay: 0, iw: 16'd16, w: 11'd16, h: 10'd8,
              x: 11'd10, y: 10'd20, color: 0};
        push_one(c);
        idle_cycles(140);

        // Back-to-back pushes past full while the gpu is busy
        for (int i = 0; i < 10; i++) begin
            drive(1, rand_cmd(1'($urandom)), 0);
            step();
        end
        idle_cycles(8 * 131 + 20);

        // Alternating DRAW / CLEAR
        op_len = 3;
        for (int i = 0; i < 6; i++) begin
            c = rand_cmd(1'(i % 2));
            if (c.op) c.color = 16'hF801;
            drive(1, c, 0);
            step();
        end
        idle_cycles(60);

        // Flush with a same-cycle push while 4 entries wait and one is in flight
        op_len = 40;
        for (int i = 0; i < 5; i++) begin
            drive(1, rand_cmd(1'($urandom)), 0);
            step();
        end
        drive(1, rand_cmd(0), 1);
        step();
        idle_cycles(60);

        // Reset during WAIT, then a fresh command
        op_len = 50;
        push_one(rand_cmd(0));
        idle_cycles(10);
        reset = 1;
        step();
        reset = 0;
        idle_cycles(2);
        op_len = 5;
        push_one(rand_cmd(1));
        idle_cycles(20);

        // Full queue with simultaneous pop and refused push
        ext_busy = 1;
        for (int i = 0; i < DEPTH; i++) begin
            drive(1, rand_cmd(1'($urandom)), 0);
            step();
        end
        ext_busy = 0;
        drive(1, rand_cmd(0), 0);
        step();
        op_len = 2;
        idle_cycles(DEPTH * 6 + 10);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            op_len   = 1 + int'($urandom_range(0, 5));
            ext_busy = ($urandom_range(0, 19) == 0);
            reset    = ($urandom_range(0, 399) == 0);
            drive(($urandom_range(0, 2) == 0), rand_cmd(1'($urandom)),
                  ($urandom_range(0, 49) == 0));
            step();
        end
        reset = 0; ext_busy = 0;
        idle_cycles(100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
